// File: rtl/dmi_dtm_core.sv
// dmi_dtm_core: JTAG DTM holding dtmcs/dmi DRs and driving the DMI request/response channel
module dmi_dtm_core #(
  parameter int ABITS = 7,
  parameter int IDLE_HINT = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tap_clear_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             update_i,
  input  logic             tdi_i,
  input  logic             dtmcs_select_i,
  input  logic             dmi_select_i,
  output logic             dtmcs_tdo_o,
  output logic             dmi_tdo_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_resp_i,
  output logic             timeout_o
);
  localparam int DW = ABITS + 34;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] dtmcs_q, data_q, data_d, read_data;
  logic [DW-1:0] dr_q;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [1:0] op_q, op_d, error_q, error_d, status;
  logic [WW-1:0] wdog_q, wdog_d;
  logic timeout_q, timeout_d;
  logic dmi_clear, dmi_reset, dmi_update, busy_read, resp_now, fire, fail_set, busy_set;
  assign dmi_clear = rst_i | tap_clear_i | (update_i & dtmcs_select_i & dtmcs_q[17]);
  assign dmi_reset = update_i & dtmcs_select_i & dtmcs_q[16];
  assign dmi_update = update_i & dmi_select_i;
  assign busy_read = state_q != IDLE && op_q == 2'd1;
  assign resp_now = state_q == WAIT && resp_valid_i;
  assign fire = TIMEOUT != 0 && state_q == WAIT && wdog_q == WMAX && !resp_valid_i;
  assign fail_set = (resp_now && resp_resp_i == 2'd2) || fire;
  assign busy_set = (resp_now && resp_resp_i == 2'd3) || (dmi_update && state_q != IDLE) ||
                    (capture_i && dmi_select_i && busy_read);
  assign status = (error_q == 2'd3 || busy_read) ? 2'd3 : error_q;
  assign read_data = resp_resp_i == 2'd0 ? resp_data_i :
                     resp_resp_i == 2'd1 ? 32'hBAADC0DE :
                     resp_resp_i == 2'd2 ? 32'hDEADBEEF : 32'hB051B051;
  assign dtmcs_tdo_o = dtmcs_q[0];
  assign dmi_tdo_o = dr_q[0];
  assign req_valid_o = state_q == REQ;
  assign req_addr_o = addr_q;
  assign req_data_o = data_q;
  assign req_op_o = op_q;
  assign resp_ready_o = 1'b1;
  assign timeout_o = timeout_q;
  // dmireset beats any error raised this cycle; otherwise the first error sticks, op-failed over busy
  assign error_d = dmi_reset ? 2'd0 : error_q != 2'd0 ? error_q : fail_set ? 2'd2 : busy_set ? 2'd3 : 2'd0;
  // dtmcs shift register: capture status layout, shift toward TDO
  always_ff @(posedge clk_i) begin
    if (rst_i) dtmcs_q <= '0;
    else if (capture_i && dtmcs_select_i) dtmcs_q <= {14'b0, 2'b00, 1'b0, 3'(IDLE_HINT), error_q, 6'(ABITS), 4'h1};
    else if (shift_i && dtmcs_select_i) dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
  end
  // dmi shift register: capture {addr, data, status}, shift toward TDO
  always_ff @(posedge clk_i) begin
    if (dmi_clear) dr_q <= '0;
    else if (capture_i && dmi_select_i) dr_q <= {addr_q, data_q, status};
    else if (shift_i && dmi_select_i) dr_q <= {tdi_i, dr_q[DW-1:1]};
  end
  // request/response state and watchdog registers
  always_ff @(posedge clk_i) begin
    if (dmi_clear) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      op_q <= '0;
      error_q <= '0;
      wdog_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      op_q <= op_d;
      error_q <= error_d;
      wdog_q <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
  // next state: launch on accepted update, hand off on ready, retire on response or watchdog
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    op_d = op_q;
    wdog_d = wdog_q;
    timeout_d = 1'b0;
    if (state_q == IDLE && dmi_update && error_q == 2'd0) begin
      addr_d = dr_q[DW-1:34];
      data_d = dr_q[33:2];
      op_d = dr_q[1:0];
      state_d = (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2) ? REQ : IDLE;
    end
    if (state_q == REQ && req_ready_i) begin
      state_d = WAIT;
      wdog_d = '0;
    end
    if (state_q == WAIT) begin
      wdog_d = wdog_q + WW'(1);
      if (resp_valid_i) begin
        state_d = IDLE;
        data_d = op_q == 2'd1 ? read_data : data_q;
      end else if (fire) begin
        state_d = IDLE;
        data_d = 32'hDEADBEEF;
        timeout_d = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmi_dtm_core.sv
// tb_dmi_dtm_core: directed scoreboard bench for the DTM core with a short watchdog
module tb_dmi_dtm_core;
  logic clk = 1'b0, rst_i, tap_clear_i, capture_i, shift_i, update_i, tdi_i;
  logic dtmcs_select_i, dmi_select_i, dtmcs_tdo_o, dmi_tdo_o;
  logic req_valid_o, req_ready_i, resp_valid_i, resp_ready_o, timeout_o;
  logic [6:0] req_addr_o;
  logic [31:0] req_data_o, resp_data_i;
  logic [1:0] req_op_o, resp_resp_i;
  int checks = 0, failures = 0;
  logic [40:0] exp_dr[$];
  logic [40:0] exp_req[$];
  logic [31:0] exp_cs[$];
  dmi_dtm_core #(.ABITS(7), .IDLE_HINT(1), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .tap_clear_i(tap_clear_i), .capture_i(capture_i),
    .shift_i(shift_i), .update_i(update_i), .tdi_i(tdi_i),
    .dtmcs_select_i(dtmcs_select_i), .dmi_select_i(dmi_select_i),
    .dtmcs_tdo_o(dtmcs_tdo_o), .dmi_tdo_o(dmi_tdo_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .req_op_o(req_op_o), .resp_valid_i(resp_valid_i),
    .resp_ready_o(resp_ready_o), .resp_data_i(resp_data_i), .resp_resp_i(resp_resp_i),
    .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic dmi_scan(input logic [40:0] din, input logic upd, input string tag);
    logic [40:0] dout;
    dout = '0;
    dmi_select_i = 1'b1;
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    shift_i = 1'b1;
    for (int i = 0; i < 41; i++) begin
      dout[i] = dmi_tdo_o;
      tdi_i = din[i];
      tick();
    end
    shift_i = 1'b0;
    if (upd) begin
      update_i = 1'b1;
      tick();
      update_i = 1'b0;
    end
    dmi_select_i = 1'b0;
    if (exp_dr.size() == 0) chk({tag, "_empty"}, 64'(0), 64'(1));
    else chk(tag, 64'(dout), 64'(exp_dr.pop_front()));
  endtask
  task automatic cs_scan(input logic [31:0] din, input logic upd, input string tag);
    logic [31:0] dout;
    dout = '0;
    dtmcs_select_i = 1'b1;
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    shift_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = dtmcs_tdo_o;
      tdi_i = din[i];
      tick();
    end
    shift_i = 1'b0;
    if (upd) begin
      update_i = 1'b1;
      tick();
      update_i = 1'b0;
    end
    dtmcs_select_i = 1'b0;
    if (exp_cs.size() == 0) chk({tag, "_empty"}, 64'(0), 64'(1));
    else chk(tag, 64'(dout), 64'(exp_cs.pop_front()));
  endtask
  task automatic req_check(input string tag);
    int n;
    n = 0;
    while (!req_valid_o && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(0));
    if (exp_req.size() == 0) chk({tag, "_empty"}, 64'(0), 64'(1));
    else chk(tag, 64'({req_addr_o, req_data_o, req_op_o}), 64'(exp_req.pop_front()));
  endtask
  task automatic accept();
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
  endtask
  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    resp_valid_i = 1'b1;
    resp_data_i = d;
    resp_resp_i = r;
    tick();
    resp_valid_i = 1'b0;
    resp_data_i = '0;
    resp_resp_i = '0;
  endtask
  initial begin
    rst_i = 1'b1;
    {tap_clear_i, capture_i, shift_i, update_i, tdi_i, dtmcs_select_i, dmi_select_i} = '0;
    {req_ready_i, resp_valid_i} = '0;
    resp_data_i = '0;
    resp_resp_i = '0;
    tick(3);
    rst_i = 1'b0;
    chk("rst_req_valid", 64'(req_valid_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_tdo", 64'({dtmcs_tdo_o, dmi_tdo_o}), 64'(0));
    chk("resp_ready", 64'(resp_ready_o), 64'(1));
    exp_cs.push_back(32'h00001071);
    cs_scan(32'h0, 1'b0, "dtmcs_idcode");
    chk("idle_req_valid", 64'(req_valid_o), 64'(0));
    exp_dr.push_back({7'h00, 32'h0, 2'd0});
    exp_req.push_back({7'h10, 32'h12345678, 2'd2});
    dmi_scan({7'h10, 32'h12345678, 2'd2}, 1'b1, "wr_prev");
    req_check("wr_req");
    tick();
    chk("wr_hold_valid", 64'(req_valid_o), 64'(1));
    accept();
    chk("wr_wait_valid", 64'(req_valid_o), 64'(0));
    respond(32'hFFFFFFFF, 2'd0);
    exp_dr.push_back({7'h10, 32'h12345678, 2'd0});
    dmi_scan('0, 1'b0, "wr_status");
    exp_dr.push_back({7'h10, 32'h12345678, 2'd0});
    exp_req.push_back({7'h11, 32'h0, 2'd1});
    dmi_scan({7'h11, 32'h0, 2'd1}, 1'b1, "rd_prev");
    req_check("rd_req");
    accept();
    respond(32'hCAFEF00D, 2'd0);
    exp_dr.push_back({7'h11, 32'hCAFEF00D, 2'd0});
    dmi_scan('0, 1'b0, "rd_data");
    exp_dr.push_back({7'h11, 32'hCAFEF00D, 2'd0});
    exp_req.push_back({7'h12, 32'h0, 2'd1});
    dmi_scan({7'h12, 32'h0, 2'd1}, 1'b1, "busy_prev");
    req_check("busy_req");
    accept();
    exp_dr.push_back({7'h12, 32'h0, 2'd3});
    dmi_scan('0, 1'b0, "busy_capture");
    exp_dr.push_back({7'h12, 32'hDEADBEEF, 2'd3});
    dmi_scan({7'h13, 32'h0, 2'd2}, 1'b1, "busy_sticky");
    chk("busy_update_ignored", 64'(req_valid_o), 64'(0));
    exp_cs.push_back(32'h00001C71);
    cs_scan(32'h00010000, 1'b1, "dtmcs_busy");
    exp_dr.push_back({7'h12, 32'hDEADBEEF, 2'd0});
    exp_req.push_back({7'h13, 32'hA5A5A5A5, 2'd2});
    dmi_scan({7'h13, 32'hA5A5A5A5, 2'd2}, 1'b1, "dmireset_cleared");
    req_check("wr2_req");
    accept();
    respond(32'h0, 2'd2);
    exp_dr.push_back({7'h13, 32'hA5A5A5A5, 2'd2});
    dmi_scan('0, 1'b0, "wr_err");
    exp_cs.push_back(32'h00001871);
    cs_scan(32'h00010000, 1'b1, "dtmcs_err");
    exp_dr.push_back({7'h13, 32'hA5A5A5A5, 2'd0});
    exp_req.push_back({7'h14, 32'h0, 2'd1});
    dmi_scan({7'h14, 32'h0, 2'd1}, 1'b1, "to_prev");
    req_check("to_req");
    accept();
    tick(15);
    chk("to_early", 64'(timeout_o), 64'(0));
    tick();
    chk("to_pulse", 64'(timeout_o), 64'(1));
    tick();
    chk("to_pulse_end", 64'(timeout_o), 64'(0));
    respond(32'h11111111, 2'd0);
    exp_dr.push_back({7'h14, 32'hDEADBEEF, 2'd2});
    dmi_scan('0, 1'b0, "to_status");
    exp_cs.push_back(32'h00001871);
    cs_scan(32'h00010000, 1'b1, "dtmcs_to");
    exp_cs.push_back(32'h00001071);
    cs_scan(32'h00020000, 1'b0, "dtmcs_arm_hard");
    exp_dr.push_back({7'h14, 32'hDEADBEEF, 2'd0});
    exp_req.push_back({7'h15, 32'h00000077, 2'd1});
    dmi_scan({7'h15, 32'h00000077, 2'd1}, 1'b1, "hr_prev");
    req_check("hr_req");
    accept();
    tick(3);
    dtmcs_select_i = 1'b1;
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    dtmcs_select_i = 1'b0;
    chk("hr_req_valid", 64'(req_valid_o), 64'(0));
    exp_dr.push_back({7'h00, 32'h0, 2'd0});
    dmi_scan('0, 1'b0, "hr_cleared");
    exp_cs.push_back(32'h00001071);
    cs_scan(32'h0, 1'b0, "hr_dtmcs");
    chk("timeout_idle", 64'(timeout_o), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
